zap_shift_stage_buffer: RTL

Registered output stage for the shift unit: captures the barrel shifter's combinational result and carry, resolves the final shifter carry-out, and presents it to the ALU stage under a valid/ready handshake. When `ZAP_SHIFT_SKID_EN` is defined, a 2-entry skid buffer decouples stalls; entries waiting on the old carry track flag updates while held. The block sits between the shifter and the ALU.

---
 rtl/zap_shift_stage_buffer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/zap_shift_stage_buffer.sv
// Registered output stage between the barrel shifter and the ALU: resolves the shifter carry-out
// and hands entries over valid/ready. Define ZAP_SHIFT_SKID_EN for a 2-entry skid buffer.
module zap_shift_stage_buffer #(
    parameter int CTX_W = 64
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_result,
    input  logic             i_carry,
    input  logic             i_use_old_carry,
    input  logic [CTX_W-1:0] i_ctx,
    input  logic             i_cpsr_c,
    input  logic             i_fwd_c_valid,
    input  logic             i_fwd_c,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_result,
    output logic             o_carry,
    output logic [CTX_W-1:0] o_ctx,
    output logic [1:0]       o_occupancy
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high,
    // on each side independently; flush discards held entries and the entry offered that cycle.

    typedef struct packed {
        logic [31:0]      result;
        logic             carry;
        logic             use_old;
        logic [CTX_W-1:0] ctx;
    } entry_t;

    logic   cap_carry;
    entry_t cap_entry;
    entry_t head_q;
    entry_t head_d;
    entry_t head_trk;
    logic   push;
    logic   pop;

    // A capture in the same cycle as a flag commit must see the new C flag, not the stale one.
    assign cap_carry = i_use_old_carry ? (i_fwd_c_valid ? i_fwd_c : i_cpsr_c) : i_carry;

    always_comb begin
        cap_entry         = '0;
        cap_entry.result  = i_result;
        cap_entry.carry   = cap_carry;
        cap_entry.use_old = i_use_old_carry;
        cap_entry.ctx     = i_ctx;
    end

    function automatic entry_t track(input entry_t e, input logic fwd_v, input logic fwd_c);
        entry_t r;
        r = e;
        if (fwd_v && e.use_old) begin
            r.carry = fwd_c;
        end
        return r;
    endfunction

    assign head_trk = track(head_q, i_fwd_c_valid, i_fwd_c);

    assign o_result = head_q.result;
    assign o_carry  = head_q.carry;
    assign o_ctx    = head_q.ctx;

`ifdef ZAP_SHIFT_SKID_EN

    entry_t     tail_q;
    entry_t     tail_d;
    entry_t     tail_trk;
    logic [1:0] occ_q;
    logic [1:0] occ_d;
    logic       ready_q;

    assign tail_trk    = track(tail_q, i_fwd_c_valid, i_fwd_c);
    assign o_ready     = ready_q;
    assign o_valid     = (occ_q != 2'd0);
    assign o_occupancy = occ_q;
    assign push        = i_valid & ready_q;
    assign pop         = o_valid & i_ready;

    always_comb begin
        head_d = head_trk;
        tail_d = tail_trk;
        occ_d  = occ_q;
        if (i_flush) begin
            head_d = head_q;
            tail_d = tail_q;
            occ_d  = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_d = cap_entry;
                    end else begin
                        tail_d = cap_entry;
                    end
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    if (occ_q == 2'd2) begin
                        head_d = tail_trk;
                    end
                    occ_d = occ_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new entry goes behind whatever remains.
                    if (occ_q == 2'd1) begin
                        head_d = cap_entry;
                    end else begin
                        head_d = tail_trk;
                        tail_d = cap_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= 2'd0;
            ready_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            ready_q <= (occ_d != 2'd2);
        end
    end

`else

    logic valid_q;
    logic valid_d;

    assign o_ready     = ~valid_q | i_ready;
    assign o_valid     = valid_q;
    assign o_occupancy = {1'b0, valid_q};
    assign push        = i_valid & o_ready;
    assign pop         = valid_q & i_ready;

    always_comb begin
        head_d  = push ? cap_entry : head_trk;
        valid_d = push | (valid_q & ~pop);
        if (i_flush) begin
            head_d  = head_q;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            valid_q <= valid_d;
        end
    end

`endif

endmodule
